// File: rtl/divider_unit_if.sv
// divider_unit_if: Start/Busy/Done handshake bundle for the 8-bit divider.
//   master : controller side, drives start and the operands, observes results
//   slave  : divider side, samples start and operands, drives q/r/busy/done/div_zero
//   start, dividend[7:0], divisor[7:0]  request and operands
//   q[7:0], r[7:0], busy, done, div_zero result and status
interface divider_unit_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       div_zero;

  modport master (
    output start, dividend, divisor,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/divider_unit.sv
// divider_unit: sequential restoring (shift-subtract) divider, 8-bit operands,
// fixed 10-cycle latency from the accepting edge to done.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    divider_unit_if.slave (start/dividend/divisor in; q/r/busy/done/div_zero out)
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (truncating quotient, remainder takes the dividend's sign); default is unsigned.
module divider_unit (
  input  logic           clk,
  input  logic           rst_n,
  divider_unit_if.slave  bus
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept_c;

  logic [W-1:0]    dvd_r;
  logic [W-1:0]    dvs_r;
  // Partial remainder never reaches the divisor, so its top bit is always zero
  // and only the low 8 bits are stored; the compare itself is done in 9 bits.
  logic [W-1:0]    p_r;
  logic [W-1:0]    qs_r;
  logic [W-1:0]    d_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    q_r;
  logic [W-1:0]    r_r;
  logic            busy_r;
  logic            done_r;
  logic            dz_r;

  logic [W:0]      p_shift_c;
  logic [W:0]      t_c;
  logic [W-1:0]    dvd_mag_c;
  logic [W-1:0]    dvs_mag_c;
  logic [W-1:0]    q_fix_c;
  logic [W-1:0]    r_fix_c;

`ifdef DIVIDER_SIGNED_EN
  logic            q_neg_r;
  logic            r_neg_r;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and start acceptance
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        state_next = S_LOAD;
        accept_c   = 1'b1;
      end
      S_LOAD: state_next = S_ITER;
      S_ITER: if (cnt_r == CW'(W - 1)) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (bus.start) begin
        state_next = S_LOAD;
        accept_c   = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One restoring step: shift {P,QS} left, trial-subtract the divisor in 9 bits
  always_comb begin
    p_shift_c = {p_r, qs_r[W-1]};
    t_c       = p_shift_c - {1'b0, d_r};
  end

  // Operand magnitudes and final result correction
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_mag_c = dvd_r[W-1] ? (~dvd_r + W'(1)) : dvd_r;
    dvs_mag_c = dvs_r[W-1] ? (~dvs_r + W'(1)) : dvs_r;
    if (dz_r) begin
      q_fix_c = '1;
      r_fix_c = dvd_r;
    end else begin
      q_fix_c = q_neg_r ? (~qs_r + W'(1)) : qs_r;
      r_fix_c = r_neg_r ? (~p_r + W'(1)) : p_r;
    end
`else
    dvd_mag_c = dvd_r;
    dvs_mag_c = dvs_r;
    q_fix_c   = qs_r;
    r_fix_c   = p_r;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r   <= '0;
      dvs_r   <= '0;
      p_r     <= '0;
      qs_r    <= '0;
      d_r     <= '0;
      cnt_r   <= '0;
      q_r     <= '0;
      r_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      if (accept_c) begin
        dvd_r <= bus.dividend;
        dvs_r <= bus.divisor;
      end
      case (state)
        S_LOAD: begin
          p_r   <= '0;
          qs_r  <= dvd_mag_c;
          d_r   <= dvs_mag_c;
          cnt_r <= '0;
          dz_r  <= (dvs_r == '0);
`ifdef DIVIDER_SIGNED_EN
          q_neg_r <= dvd_r[W-1] ^ dvs_r[W-1];
          r_neg_r <= dvd_r[W-1];
`endif
        end
        S_ITER: begin
          if (!t_c[W]) begin
            p_r  <= t_c[W-1:0];
            qs_r <= {qs_r[W-2:0], 1'b1};
          end else begin
            p_r  <= p_shift_c[W-1:0];
            qs_r <= {qs_r[W-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
        end
        S_FIX: begin
          q_r <= q_fix_c;
          r_r <= r_fix_c;
        end
        default: ;
      endcase
      busy_r <= (state_next == S_LOAD) || (state_next == S_ITER) || (state_next == S_FIX);
      done_r <= (state_next == S_DONE);
    end
  end

  assign bus.q        = q_r;
  assign bus.r        = r_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;

endmodule
